// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic OWNER_CORE   = 1'b0;
  localparam logic OWNER_LOADER = 1'b1;
  localparam int   ARB_LATENCY  = 3;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - combinational two-way round-robin choice
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic c_req,
  input  logic l_req,
  input  logic rr_last,
  output logic valid,
  output logic pick
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    valid = c_req | l_req;
    if (c_req && l_req) pick = ~rr_last;
    else if (l_req)     pick = OWNER_LOADER;
    else                pick = OWNER_CORE;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - 4-cycle single-port memory arbiter, core vs loader
// Optional grant/stall counters when MEM_ARB_STATS_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
`ifdef MEM_ARB_STATS_EN
  ,
  parameter int STAT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_ack,
  output logic [DATA_WIDTH-1:0] c_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_ack,
  output logic [DATA_WIDTH-1:0] l_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] c_grants,
  output logic [STAT_WIDTH-1:0] l_grants,
  output logic [STAT_WIDTH-1:0] stall_cycles
`endif
);

  arb_state_t state;
  logic       rr_last;
  logic       cur_we;
  logic       pick_valid;
  logic       pick_owner;

  rr_picker u_rr_picker (
    .c_req   (c_req),
    .l_req   (l_req),
    .rr_last (rr_last),
    .valid   (pick_valid),
    .pick    (pick_owner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      cur_we    <= 1'b0;
      c_rdata   <= '0;
      l_rdata   <= '0;
      c_ack     <= 1'b0;
      l_ack     <= 1'b0;
      busy      <= 1'b0;
      owner     <= OWNER_CORE;
      rr_last   <= OWNER_LOADER;
    end else begin
      c_ack <= 1'b0;
      l_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            mem_addr  <= (pick_owner == OWNER_LOADER) ? l_addr  : c_addr;
            mem_wdata <= (pick_owner == OWNER_LOADER) ? l_wdata : c_wdata;
            mem_we    <= (pick_owner == OWNER_LOADER) ? l_we    : c_we;
            cur_we    <= (pick_owner == OWNER_LOADER) ? l_we    : c_we;
            owner     <= pick_owner;
            rr_last   <= pick_owner;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Memory samples the write at this edge; drop we so it lands once.
          mem_we <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (!cur_we) begin
            if (owner == OWNER_LOADER) l_rdata <= mem_rdata;
            else                       c_rdata <= mem_rdata;
          end
          if (owner == OWNER_LOADER) l_ack <= 1'b1;
          else                       c_ack <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic c_stall;
  logic l_stall;

  // A requester is served this cycle if it is being granted now or owns the access in flight.
  always_comb begin
    c_stall = c_req && !((state == IDLE) ? (pick_valid && pick_owner == OWNER_CORE)
                                         : (owner == OWNER_CORE));
    l_stall = l_req && !((state == IDLE) ? (pick_valid && pick_owner == OWNER_LOADER)
                                         : (owner == OWNER_LOADER));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_grants     <= '0;
      l_grants     <= '0;
      stall_cycles <= '0;
    end else begin
      if (state == IDLE && pick_valid && pick_owner == OWNER_CORE && !(&c_grants))
        c_grants <= c_grants + 1'b1;
      if (state == IDLE && pick_valid && pick_owner == OWNER_LOADER && !(&l_grants))
        l_grants <= l_grants + 1'b1;
      if ((c_stall || l_stall) && !(&stall_cycles))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 12;
`ifdef MEM_ARB_STATS_EN
  localparam int SW = 2;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          c_req = 0, c_we = 0, l_req = 0, l_we = 0;
  logic [AW-1:0] c_addr = '0, l_addr = '0;
  logic [DW-1:0] c_wdata = '0, l_wdata = '0;
  logic          c_ack, l_ack, mem_we, busy, owner;
  logic [DW-1:0] c_rdata, l_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
`ifdef MEM_ARB_STATS_EN
  logic [SW-1:0] c_grants, l_grants, stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
`ifdef MEM_ARB_STATS_EN
    , .STAT_WIDTH (SW)
`endif
  ) dut (
    .clk (clk), .reset (reset),
    .c_req (c_req), .c_we (c_we), .c_addr (c_addr), .c_wdata (c_wdata),
    .c_ack (c_ack), .c_rdata (c_rdata),
    .l_req (l_req), .l_we (l_we), .l_addr (l_addr), .l_wdata (l_wdata),
    .l_ack (l_ack), .l_rdata (l_rdata),
    .mem_addr (mem_addr), .mem_we (mem_we), .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata), .busy (busy), .owner (owner)
`ifdef MEM_ARB_STATS_EN
    , .c_grants (c_grants), .l_grants (l_grants), .stall_cycles (stall_cycles)
`endif
  );

  // Memory with registered read, plus a preload port for the bench.
  logic          pl_we = 0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] mem_array [0:4095];

  always @(posedge clk) begin
    if (pl_we) mem_array[pl_addr] <= pl_data;
    else if (mem_we) mem_array[mem_addr] <= mem_wdata;
    mem_rdata <= mem_array[mem_addr];
  end

  // Reference model: cycles elapsed since the last grant decide every output.
  int            since_grant;
  logic          m_owner, m_rr_last, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_read_val, m_c_rdata, m_l_rdata;
  logic [DW-1:0] ref_mem [0:4095];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      since_grant <= 0;
      m_owner <= 0; m_rr_last <= 1; m_we <= 0;
      m_addr <= '0; m_wdata <= '0; m_c_rdata <= '0; m_l_rdata <= '0;
    end else begin
      if (pl_we) ref_mem[pl_addr] <= pl_data;
      if (since_grant == 0) begin
        if (c_req || l_req) begin
          logic who;
          who = (c_req && l_req) ? !m_rr_last : l_req;
          m_owner <= who; m_rr_last <= who;
          m_addr  <= who ? l_addr  : c_addr;
          m_wdata <= who ? l_wdata : c_wdata;
          m_we    <= who ? l_we    : c_we;
          if (who ? l_we : c_we) ref_mem[who ? l_addr : c_addr] <= who ? l_wdata : c_wdata;
          else m_read_val <= ref_mem[who ? l_addr : c_addr];
          since_grant <= 1;
        end
      end else begin
        if (since_grant == ARB_LATENCY - 1 && !m_we) begin
          if (m_owner) m_l_rdata <= m_read_val;
          else         m_c_rdata <= m_read_val;
        end
        since_grant <= (since_grant == ARB_LATENCY) ? 0 : since_grant + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Compare process plus event counters used by the directed tests.
  logic cmp_en = 0;
  int   c_ack_n = 0, l_ack_n = 0, we_cycles = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, since_grant != 0);
      chk("owner", owner, m_owner);
      chk("c_ack", c_ack, since_grant == ARB_LATENCY && m_owner == 0);
      chk("l_ack", l_ack, since_grant == ARB_LATENCY && m_owner == 1);
      chk("mem_we", mem_we, since_grant == 1 && m_we);
      chk("mem_addr", mem_addr, m_addr);
      if (mem_we) chk("mem_wdata", mem_wdata, m_wdata);
      chk("c_rdata", c_rdata, m_c_rdata);
      chk("l_rdata", l_rdata, m_l_rdata);
    end
    if (c_ack) c_ack_n++;
    if (l_ack) l_ack_n++;
    if (mem_we) we_cycles++;
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk); #1;
    pl_we = 1; pl_addr = a; pl_data = d;
    @(negedge clk); #1;
    pl_we = 0;
  endtask

  task automatic core_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output int lat);
    lat = 0;
    @(negedge clk); #1;
    c_req = 1; c_we = we; c_addr = a; c_wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (c_ack) break;
    end
    if (!c_ack) chk("core_ack_timeout", 0, 1);
    #1 c_req = 0;
  endtask

  task automatic loader_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               output int lat);
    lat = 0;
    @(negedge clk); #1;
    l_req = 1; l_we = we; l_addr = a; l_wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (l_ack) break;
    end
    if (!l_ack) chk("loader_ack_timeout", 0, 1);
    #1 l_req = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1 reset = 1;
    @(negedge clk); @(negedge clk); #1 reset = 0;
  endtask

  initial begin
    int lat, we0, ca0, la0, n;
    string order;
    int ack_at [4];

    @(negedge clk); @(negedge clk); #1 reset = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_l_ack", l_ack, 0);
    cmp_en = 1;

    preload(12'h005, 12'hABC);
    preload(12'h006, 12'h777);

    // Core read
    we0 = we_cycles; la0 = l_ack_n;
    core_access(0, 12'h005, 12'h000, lat);
    chk("read_latency", lat, ARB_LATENCY);
    chk("read_rdata", c_rdata, 12'hABC);
    #2 chk("read_no_we", we_cycles - we0, 0);
    chk("read_no_l_ack", l_ack_n - la0, 0);

    // Loader write then core read back
    we0 = we_cycles;
    loader_access(1, 12'h010, 12'h123, lat);
    chk("write_latency", lat, ARB_LATENCY);
    #2 chk("write_we_cycles", we_cycles - we0, 1);
    core_access(0, 12'h010, 12'h000, lat);
    chk("readback_rdata", c_rdata, 12'h123);

    // Address change after grant is ignored
    @(negedge clk); #1;
    c_req = 1; c_we = 0; c_addr = 12'h005;
    @(negedge clk); #1 c_addr = 12'h006;
    for (int i = 0; i < 10 && !c_ack; i++) @(negedge clk);
    chk("field_change_ack", c_ack, 1);
    #1 c_req = 0;
    chk("field_change_rdata", c_rdata, 12'hABC);

    // Reset during WAIT of a core read
    ca0 = c_ack_n;
    @(negedge clk); #1;
    c_req = 1; c_we = 0; c_addr = 12'h006;
    @(negedge clk); @(negedge clk); #2;
    reset = 1; c_req = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_mem_we", mem_we, 0);
    chk("abort_c_ack", c_ack, 0);
    chk("abort_c_rdata", c_rdata, 0);
    @(negedge clk); #1 reset = 0;
    repeat (4) @(negedge clk);
    chk("abort_no_ack", c_ack_n - ca0, 0);
    core_access(0, 12'h006, 12'h000, lat);
    chk("post_reset_latency", lat, ARB_LATENCY);
    chk("post_reset_rdata", c_rdata, 12'h777);

    // Both requesting from reset: strict alternation
    pulse_reset();
    @(negedge clk); #1;
    c_req = 1; c_we = 0; c_addr = 12'h005;
    l_req = 1; l_we = 0; l_addr = 12'h010;
    order = ""; n = 0;
    for (int cyc = 1; cyc <= 40 && n < 4; cyc++) begin
      @(negedge clk);
      if (c_ack || l_ack) begin
        order = {order, c_ack ? "C" : "L"};
        ack_at[n] = cyc;
        n++;
      end
    end
    #1 c_req = 0; l_req = 0;
    chk("alt_count", n, 4);
    chk("alt_order", (order == "CLCL") ? 1 : 0, 1);
    if (n == 4) begin
      chk("alt_first", ack_at[0], ARB_LATENCY);
      for (int k = 1; k < 4; k++) chk("alt_spacing", ack_at[k] - ack_at[k-1], 4);
    end
    chk("alt_l_rdata", l_rdata, 12'h123);
    chk("alt_c_rdata", c_rdata, 12'hABC);

`ifdef MEM_ARB_STATS_EN
    @(negedge clk);
    chk("stat_c_grants", c_grants, 2);
    chk("stat_l_grants", l_grants, 2);
    chk("stat_stall_nonzero", stall_cycles != 0, 1);
    for (int k = 0; k < 3; k++) core_access(0, 12'h005, 12'h000, lat);
    @(negedge clk);
    chk("stat_c_saturate", c_grants, {SW{1'b1}});
    chk("stat_l_unchanged", l_grants, 2);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port 12-bit main memory between two requesters:
  - core (C): instruction fetch and data load/store;
  - loader (L): UART program loader / debug port.
- Sequences every access through a fixed 4-cycle issue/wait/respond protocol that matches the memory's registered read.
- Round-robin fairness between the two requesters.
- Sits between the core datapath, the UART receive path and the main memory instance.

Parameters:
- ADDR_WIDTH, 12, memory address width.
- DATA_WIDTH, 12, memory word width.
- STAT_WIDTH, 16, width of grant counters (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- c_req  in  1  core request; held until c_ack
- c_we  in  1  core write (1) / read (0)
- c_addr  in  ADDR_WIDTH  core address
- c_wdata  in  DATA_WIDTH  core write data
- c_ack  out  1  one-cycle completion pulse to core
- c_rdata  out  DATA_WIDTH  core read data, valid while c_ack=1 and held afterwards
- l_req, l_we, l_addr, l_wdata, l_ack, l_rdata: same set and semantics for the loader
- mem_addr  out  ADDR_WIDTH  to memory addr
- mem_we  out  1  to memory write_enable
- mem_wdata  out  DATA_WIDTH  to memory data_in
- mem_rdata  in  DATA_WIDTH  from memory data_out (synchronous read, 1-cycle)
- busy  out  1  1 whenever state != IDLE
- owner  out  1  0=core, 1=loader; current/last granted requester

Behaviour:
- Reset:
  - clk and reset are a single clock domain; reset is asynchronous, active-high.
  - On reset: state=IDLE; mem_addr, mem_wdata, c_rdata, l_rdata = 0; mem_we, c_ack, l_ack, busy = 0; owner=0; rr_last=1 (core wins the first tie).
- IDLE:
  - If no request: stay.
  - If exactly one request: grant it.
  - If both request: grant the requester != rr_last.
  - On grant, register the granted addr/we/wdata into mem_addr/mem_we/mem_wdata; set owner and rr_last to the grantee; go to ISSUE.
- ISSUE (1 cycle): the memory samples addr/we/data at the closing edge. Clear mem_we at that edge so exactly one write occurs; go to WAIT.
- WAIT (1 cycle): mem_rdata is valid. At the closing edge, copy mem_rdata into the owner's rdata (reads only; writes leave rdata unchanged); go to RESP.
- RESP (1 cycle): the owner's ack=1; go to IDLE.
- Timing:
  - Latency is fixed: ack is asserted 3 cycles after the grant edge.
  - Maximum throughput is one access per 4 cycles.
  - The non-granted requester waits at least 4 cycles.
- Requester rules:
  - Request fields are sampled only at the grant edge; later changes are ignored.
  - A requester deasserts req during its ack cycle. A req still high in IDLE is treated as a new transaction.
- Boundary conditions:
  - Req dropped before ack: the transaction completes and ack still pulses.
  - Both requesting continuously: strict alternation C, L, C, L...
  - Address beyond memory depth: passed through unchanged; the memory defines the result.
  - Reset mid-operation: immediate return to IDLE with mem_we=0. An in-flight write may or may not have landed. No ack is issued for the aborted transaction.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- With the macro defined:
  - Extra outputs c_grants and l_grants, each STAT_WIDTH wide.
  - Each counter increments at its requester's grant edge and saturates at all-ones.
  - Extra output stall_cycles, STAT_WIDTH wide: counts cycles where a req is high but not granted, including while busy; saturating.
  - All counters reset to 0.
- Without the macro: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - arb_state_t enum (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - OWNER_CORE=1'b0 and OWNER_LOADER=1'b1 constants;
  - the fixed latency constant ARB_LATENCY=3.
- One natural sub-module, rr_picker: a combinational 2-way round-robin choice from the two reqs and rr_last. Everything else stays in mem_arbiter.

Test Plan:
- Core read: preload mem[0x005]=0xABC; c_req=1, c_we=0, c_addr=0x005 -> c_ack pulses exactly 3 cycles after grant with c_rdata=0xABC; l_ack stays 0; mem_we never 1.
- Loader write then core read: l_we=1, l_addr=0x010, l_wdata=0x123 -> mem_we high for exactly one cycle, then l_ack. Next, core reads 0x010 -> 0x123.
- Simultaneous requests from reset: c_req and l_req both held for 4 transactions -> grant order C, L, C, L; owner toggles; each ack 4 cycles apart.
- Field change after grant: change c_addr from 0x005 to 0x006 during ISSUE -> memory still sees 0x005 and c_rdata equals mem[0x005].
- Reset in WAIT of a core read -> outputs return to reset values asynchronously, no c_ack. A fresh request after reset completes normally.
- With MEM_ARB_STATS_EN: run the simultaneous-request test -> c_grants=2, l_grants=2, stall_cycles>0. Force c_grants to all-ones minus 1 and issue 3 more core requests -> it saturates at all-ones.
